apb_regfile_responder: RTL and testbench
========================================

Name: apb_regfile_responder

Overview:
- APB-style completer at the far end of the team's clock-crossing APB bridge; it terminates the bridge's slave-side request channel.
- Holds NUM_REGS read/write word registers plus one read-only status word.
- Inserts a programmable number of wait states and flags slave errors for illegal accesses.
- Register contents drive peripheral control logic in the same clock domain.

Parameters:
- ADDR_WIDTH, 8, byte address width of sapb_paddr.
- DATA_WIDTH, 32, data width; only 32 is supported (word addressing uses paddr[1:0]).
- NUM_REGS, 8, number of RW registers; legal range 1..63.
- WAIT_CYCLES, 0, extra access-phase cycles before pready; legal range 0..15.
- RESET_VALUE, 0, reset value of every RW register.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sapb_psel  in  1  select.
- sapb_penable  in  1  access phase.
- sapb_paddr  in  ADDR_WIDTH  byte address.
- sapb_pwrite  in  1  1 = write.
- sapb_pwdata  in  DATA_WIDTH  write data.
- sapb_prdata  out  DATA_WIDTH  read data.
- sapb_pready  out  1  transfer complete.
- sapb_pslverr  out  1  error; valid only while pready=1.
- status_in  in  DATA_WIDTH  sampled live at RO index NUM_REGS.
- reg_vector  out  NUM_REGS*DATA_WIDTH  RW registers, register i at bits [i*32 +: 32].
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on a committed write.

Behaviour:
- Reset: rst=1 on a clock edge gives FSM=IDLE, wait counter=0, all registers=RESET_VALUE, pready=0, pslverr=0, prdata=0, wr_pulse=0.
- Reset asserted mid-transfer aborts the transfer; no write is committed.
- Addressing: idx = paddr[ADDR_WIDTH-1:2].
  - idx < NUM_REGS: RW register.
  - idx == NUM_REGS: RO status word.
  - idx > NUM_REGS: unmapped.
- Error conditions: paddr[1:0] != 0, unmapped idx, or a write to the RO index.
- FSM states:
  - IDLE: psel=1 and penable=0 (setup) -> SETUP. psel=1 and penable=1 with no prior setup is a protocol violation: ignore it and stay in IDLE with pready=0.
  - SETUP: latch addr, pwrite and pwdata; clear the counter; go to ACCESS on the next edge, independent of penable.
  - ACCESS: pready = (cnt == WAIT_CYCLES) & psel & penable, combinational from state. The counter increments each ACCESS cycle until it saturates at WAIT_CYCLES.
    - On pready=1 -> IDLE, or -> SETUP if a new setup is presented in the following cycle (normal IDLE handling applies).
    - psel dropped in ACCESS before pready -> IDLE, no commit, no wr_pulse.
- Latency: setup-to-pready is 1+WAIT_CYCLES cycles. With WAIT_CYCLES=0, pready rises in the first access cycle.
- Write commit: on the clk edge where pready=1 and pwrite=1 with no error, reg[idx] <= latched pwdata. wr_pulse[idx]=1 for exactly the following cycle.
- Failed writes: an erroring write changes no register and raises no pulse.
- Read data: prdata is driven only while pready=1 & !pwrite & !error; otherwise 0.
  - RW read returns the register value before any same-cycle update.
  - RO read returns status_in in the pready cycle.
- Error timing: pslverr = error while pready=1, else 0. prdata=0 on an error.
- Back-to-back transfers are fully supported; every transfer takes at least 2 cycles.
- Address, pwrite and pwdata are latched in SETUP. Changes during ACCESS are ignored.

Decomposition:
- Shared package, apb_regfile_pkg:
  - FSM state encoding constants IDLE=0, SETUP=1, ACCESS=2.
  - APB word offset width constant (2).
  - Error-condition helper function.
- Sub-module apb_wait_counter: saturating counter with clear, enable and terminal-count outputs. It is instantiated once and is reusable by other completers.

Test Plan:
- Write 0xDEADBEEF to paddr 0x04 (WAIT_CYCLES=0) -> pready in cycle 2, pslverr=0, reg_vector[63:32]=0xDEADBEEF one cycle later, wr_pulse=0b00000010 for 1 cycle.
- Read paddr 0x04 after that write with WAIT_CYCLES=3 -> pready in cycle 5 exactly, prdata=0xDEADBEEF, prdata=0 in all other cycles.
- Read RO index 0x20 with status_in=0x12345678 -> prdata=0x12345678, pslverr=0. Write to 0x20 -> pslverr=1, registers unchanged, wr_pulse=0.
- Unaligned paddr 0x06 and unmapped paddr 0x40 -> pready=1 with pslverr=1, prdata=0, no register change.
- Drop psel mid-ACCESS with WAIT_CYCLES=5 on a write of 0x55 to 0x00 -> no pready, reg0 unchanged, next transfer completes normally.
- Assert rst for 1 cycle during ACCESS of a write -> FSM IDLE, all registers RESET_VALUE, pready=0, no wr_pulse. A subsequent read of 0x00 returns RESET_VALUE.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared definitions for the APB register-file completer: FSM encoding,
// word-offset width and the access-error decode.
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Low address bits that select a byte within a 32-bit word.
  localparam int unsigned APB_WORD_OFFS_W = 2;

  // An access errors when it is unaligned, lands beyond the status word,
  // or tries to write the read-only status word (index == num_regs).
  function automatic logic apb_access_err(
    input logic [1:0]  offs,
    input int unsigned idx,
    input int unsigned num_regs,
    input logic        wr
  );
    return (offs != 2'b00) || (idx > num_regs) || (wr && (idx == num_regs));
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Saturating wait-state counter: clear has priority, then count while
// enabled until MAX is reached; tc flags the terminal count.
module apb_wait_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == WIDTH'(MAX));

  // Next count: clear, increment below the limit, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_regfile_responder.sv
// APB completer terminating the bridge's slave-side channel: NUM_REGS RW
// words, one live read-only status word, programmable wait states and
// slave-error reporting for illegal accesses.
module apb_regfile_responder
  import apb_regfile_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sapb_psel,
  input  logic                           sapb_penable,
  input  logic [ADDR_WIDTH-1:0]          sapb_paddr,
  input  logic                           sapb_pwrite,
  input  logic [DATA_WIDTH-1:0]          sapb_pwdata,
  output logic [DATA_WIDTH-1:0]          sapb_prdata,
  output logic                           sapb_pready,
  output logic                           sapb_pslverr,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_vector,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - APB_WORD_OFFS_W;
  localparam int unsigned CNT_W = 4;

  apb_state_e state_q, state_d, cur_state;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [IDX_W-1:0]      idx;
  logic                  access_err;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]      wait_cnt;

  assign idx        = addr_q[ADDR_WIDTH-1:APB_WORD_OFFS_W];
  assign access_err = apb_access_err(addr_q[APB_WORD_OFFS_W-1:0], 32'(idx), NUM_REGS, pwrite_q);
  assign wr_pulse   = wr_pulse_q;

  apb_wait_counter #(
    .WIDTH (CNT_W),
    .MAX   (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (wait_cnt),
    .tc  (cnt_tc)
  );

  // Transfer FSM; a setup seen while idle is handled as the SETUP phase of
  // that same cycle so the first access cycle can already complete.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    sapb_pready = 1'b0;
    cur_state   = state_q;
    if ((state_q == IDLE) && sapb_psel && !sapb_penable) begin
      cur_state = SETUP;
    end else begin
      cur_state = state_q;
    end
    case (cur_state)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        addr_d   = sapb_paddr;
        pwrite_d = sapb_pwrite;
        pwdata_d = sapb_pwdata;
        cnt_clr  = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        cnt_en = !cnt_tc;
        if (!sapb_psel) begin
          state_d = IDLE;
        end else if ((wait_cnt == CNT_W'(WAIT_CYCLES)) && sapb_penable) begin
          sapb_pready = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register read mux, write commit, strobe generation and response data.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    rd_reg     = '0;
    commit     = sapb_pready && pwrite_q && !access_err;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_reg = regs_q[i];
        if (commit) begin
          regs_d[i]     = pwdata_q;
          wr_pulse_d[i] = 1'b1;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if (sapb_pready && !pwrite_q && !access_err) begin
      sapb_prdata = (idx == IDX_W'(NUM_REGS)) ? status_in : rd_reg;
    end else begin
      sapb_prdata = '0;
    end
    sapb_pslverr = sapb_pready && access_err;
  end

  // Flatten the register array onto the peripheral-facing bus.
  always_comb begin
    reg_vector = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_vector[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // State, latched request and register storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_regfile_responder.sv
// Self-checking bench: three completers (0, 3 and 5 wait states) on a shared
// bus with per-instance select, checked against an array model of the map.
module tb_apb_regfile_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel [3];
  logic        penable;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] status_in;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [255:0] regv [3];
  logic [7:0]  wrp [3];

  int          wc [3];
  logic [31:0] rv [3];
  logic [31:0] model [3][8];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  apb_regfile_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .sapb_psel(psel[0]), .sapb_penable(penable), .sapb_paddr(paddr),
    .sapb_pwrite(pwrite), .sapb_pwdata(pwdata), .sapb_prdata(prdata[0]), .sapb_pready(pready[0]),
    .sapb_pslverr(pslverr[0]), .status_in(status_in), .reg_vector(regv[0]), .wr_pulse(wrp[0]));

  apb_regfile_responder #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .sapb_psel(psel[1]), .sapb_penable(penable), .sapb_paddr(paddr),
    .sapb_pwrite(pwrite), .sapb_pwdata(pwdata), .sapb_prdata(prdata[1]), .sapb_pready(pready[1]),
    .sapb_pslverr(pslverr[1]), .status_in(status_in), .reg_vector(regv[1]), .wr_pulse(wrp[1]));

  apb_regfile_responder #(.WAIT_CYCLES(5), .RESET_VALUE(32'hA5A5_0001)) dut2 (
    .clk(clk), .rst(rst), .sapb_psel(psel[2]), .sapb_penable(penable), .sapb_paddr(paddr),
    .sapb_pwrite(pwrite), .sapb_pwdata(pwdata), .sapb_prdata(prdata[2]), .sapb_pready(pready[2]),
    .sapb_pslverr(pslverr[2]), .status_in(status_in), .reg_vector(regv[2]), .wr_pulse(wrp[2]));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[d][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) model[d][i] = rv[d];
  endtask

  // One complete transfer on instance d with fixed setup/access timing.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] st);
    logic [5:0]  idx;
    logic        err;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pulse;
    idx = a[7:2];
    err = (a[1:0] != 2'b00) || (idx > 6'd8) || (wr && (idx == 6'd8));
    status_in = st;
    exp_rd = 32'h0;
    if (!wr && !err) exp_rd = (idx == 6'd8) ? st : model[d][idx[2:0]];
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(negedge clk);
    chk("setup_pready", 256'(pready[d]), 256'(1'b0));
    @(posedge clk); #1;
    penable = 1'b1; paddr = 8'($urandom); pwdata = $urandom; pwrite = ~wr;
    for (int k = 1; k <= wc[d] + 1; k++) begin
      @(negedge clk);
      if (k <= wc[d]) begin
        chk("wait_pready", 256'(pready[d]), 256'(1'b0));
        chk("wait_prdata", 256'(prdata[d]), 256'(32'h0));
      end else begin
        chk("pready", 256'(pready[d]), 256'(1'b1));
        chk("pslverr", 256'(pslverr[d]), 256'(err));
        chk("prdata", 256'(prdata[d]), 256'(exp_rd));
      end
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable = 1'b0;
    exp_pulse = 8'h00;
    if (wr && !err) begin
      model[d][idx[2:0]] = wd;
      exp_pulse[idx[2:0]] = 1'b1;
    end
    @(negedge clk);
    chk("wr_pulse", 256'(wrp[d]), 256'(exp_pulse));
    chk("reg_vector", regv[d], pack(d));
    chk("idle_pready", 256'(pready[d]), 256'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk("wr_pulse_end", 256'(wrp[d]), 256'(8'h00));
  endtask

  // Write abandoned after two access cycles by dropping psel or by reset.
  task automatic abort_xfer(input int d, input logic [7:0] a, input logic [31:0] wd, input bit use_rst);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = wd;
    @(negedge clk);
    chk("ab_setup_pready", 256'(pready[d]), 256'(1'b0));
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("ab_wait_pready", 256'(pready[d]), 256'(1'b0));
      @(posedge clk); #1;
    end
    if (use_rst) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
    end
    psel[d] = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ab_pready", 256'(pready[d]), 256'(1'b0));
    chk("ab_wr_pulse", 256'(wrp[d]), 256'(8'h00));
    chk("ab_reg_vector", regv[d], pack(d));
    @(posedge clk);
    @(negedge clk);
    chk("ab_wr_pulse2", 256'(wrp[d]), 256'(8'h00));
    chk("ab_reg_vector2", regv[d], pack(d));
  endtask

  initial begin
    logic [7:0] a;
    int         d;
    wc[0] = 0; wc[1] = 3; wc[2] = 5;
    rv[0] = 32'h0; rv[1] = 32'h0; rv[2] = 32'hA5A5_0001;
    model_reset();
    rst = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0; pwdata = 32'h0; status_in = 32'h0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_pready", 256'(pready[i]), 256'(1'b0));
      chk("rst_pslverr", 256'(pslverr[i]), 256'(1'b0));
      chk("rst_prdata", 256'(prdata[i]), 256'(32'h0));
      chk("rst_wr_pulse", 256'(wrp[i]), 256'(8'h00));
      chk("rst_regs", regv[i], pack(i));
    end

    // Access phase without a preceding setup is ignored.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("noset_pready", 256'(pready[0]), 256'(1'b0));
      @(posedge clk); #1;
    end
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("noset_regs", regv[0], pack(0));

    // Directed scenarios.
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0);
    xfer(1, 1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0);
    xfer(1, 1'b0, 8'h04, 32'h0, 32'h0);
    xfer(0, 1'b0, 8'h20, 32'h0, 32'h1234_5678);
    xfer(0, 1'b1, 8'h20, 32'hCAFE_F00D, 32'h1234_5678);
    xfer(0, 1'b0, 8'h06, 32'h0, 32'h0);
    xfer(0, 1'b1, 8'h06, 32'h1111_2222, 32'h0);
    xfer(0, 1'b0, 8'h40, 32'h0, 32'h0);
    xfer(0, 1'b1, 8'h40, 32'h3333_4444, 32'h0);
    abort_xfer(2, 8'h00, 32'h0000_0055, 1'b0);
    xfer(2, 1'b1, 8'h00, 32'h0000_0055, 32'h0);
    xfer(2, 1'b0, 8'h00, 32'h0, 32'h0);
    xfer(2, 1'b1, 8'h1C, 32'h0BAD_CAFE, 32'h0);
    abort_xfer(2, 8'h04, 32'h0000_0077, 1'b1);
    xfer(2, 1'b0, 8'h00, 32'h0, 32'h0);

    // Randomized traffic over legal, status, unaligned and unmapped addresses.
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0, 1, 2: a = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
        3:       a = 8'h20;
        4:       a = {2'b00, 4'($urandom_range(0, 8)), 2'($urandom_range(1, 3))};
        default: a = {6'($urandom_range(9, 63)), 2'b00};
      endcase
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
